// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing derivation,
// common to uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned bit_rate);
    return clk_freq / bit_rate;
  endfunction

  // Transmitter counts 0..CLKS_PER_BIT inclusive, so one bit lasts one extra clock.
  function automatic int unsigned bit_period(input int unsigned clk_freq,
                                             input int unsigned bit_rate);
    return clks_per_bit(clk_freq, bit_rate) + 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a
// configurable reset value.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= i_d;
      s2_q <= s1_q;
    end
  end

  assign o_q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, PAYLOAD_BITS data bits LSB first, one stop bit.
// Emits a one-cycle o_rx_done with the word, or o_frame_err on a bad stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned CLK_FREQ     = 10_000_000,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_serial_data,
  output logic [PAYLOAD_BITS-1:0] o_data,
  output logic                    o_rx_done,
  output logic                    o_frame_err,
  output logic                    o_rx_busy
);

  localparam int unsigned BIT_PERIOD = bit_period(CLK_FREQ, BIT_RATE);
  localparam int unsigned HALF       = BIT_PERIOD / 2;
  localparam int unsigned CW         = $clog2(BIT_PERIOD) + 1;
  localparam int unsigned BW         = $clog2(PAYLOAD_BITS) + 1;
  localparam int unsigned IW         = $clog2(PAYLOAD_BITS);

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (i_serial_data),
    .o_q   (rx_s)
  );

  uart_state_e             state_q,   state_d;
  logic [CW-1:0]           clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0] shift_q,   shift_d;
  logic [PAYLOAD_BITS-1:0] data_q,    data_d;
  logic                    done_q,    done_d;
  logic                    err_q,     err_d;
  logic                    busy_q,    busy_d;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rx_s) state_d = START_BIT;
      end
      START_BIT: begin
        // Mid-start check: a line already back high was only a glitch.
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d                  = '0;
          shift_d[bit_cnt_q[IW-1:0]] = rx_s;
          bit_cnt_d                  = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = STOP_BIT;
          end
        end
      end
      STOP_BIT: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = err_q;
  assign o_rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial line driver feeds frames and a
// scoreboard of expected done / frame-error events is checked at each pulse.
module tb_uart_rx;

  localparam int BP   = 87;
  localparam int HALF = 43;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_rx_busy;

  uart_rx #(
    .BIT_RATE     (115200),
    .CLK_FREQ     (10_000_000),
    .PAYLOAD_BITS (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_serial_data (ser),
    .o_data        (o_data),
    .o_rx_done     (o_rx_done),
    .o_frame_err   (o_frame_err),
    .o_rx_busy     (o_rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_data;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cnt = 0;
  logic prev_pulse = 1'b0;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_pulse = 1'b0;
    end else begin
      if (o_rx_done || o_frame_err) begin
        n_vec++;
        if (o_rx_done && o_frame_err) begin
          n_err++;
          $display("FAIL excl: done=%0b err=%0b, required not both", o_rx_done, o_frame_err);
        end
        n_vec++;
        if (prev_pulse) begin
          n_err++;
          $display("FAIL pulse_width: pulse high for 2 cycles, required 1");
        end
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b data=%h, required none",
                   o_rx_done, o_frame_err, o_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_err != o_frame_err || o_data != e.data) begin
            n_err++;
            $display("FAIL frame: got err=%0b data=%h, required err=%0b data=%h",
                     o_frame_err, o_data, e.is_err, e.data);
          end
        end
      end
      prev_pulse = o_rx_done | o_frame_err;
      if (o_rx_busy) busy_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ser = 1'b0;
    tick(BP);
    for (int i = 0; i < 8; i++) begin
      ser = b[i];
      tick(BP);
    end
    ser = stop;
    tick(BP);
  endtask

  task automatic push(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d events outstanding after %0d cycles, required 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h00, 8'h00};
    vecs[1] = '{8'hFF, 8'hFF};
    vecs[2] = '{8'h3C, 8'h3C};
    vecs[3] = '{8'hC3, 8'hC3};
    vecs[4] = '{8'h01, 8'h01};
    vecs[5] = '{8'h80, 8'h80};

    // Reset state
    tick(3);
    chk("rst_data", 32'(o_data), 32'h0);
    chk("rst_done", 32'(o_rx_done), 32'h0);
    chk("rst_err", 32'(o_frame_err), 32'h0);
    chk("rst_busy", 32'(o_rx_busy), 32'h0);
    reset = 1'b0;
    tick(5);

    // Nominal frame with busy-duration check
    busy_cnt = 0;
    push(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_drain(2 * BP);
    tick(10);
    chk("busy_len", 32'(busy_cnt), 32'(HALF + 9 * BP));

    // Back-to-back table vectors, no idle gap
    foreach (vecs[i]) begin
      push(1'b0, vecs[i].exp_data);
      send_frame(vecs[i].data, 1'b1);
    end
    wait_drain(2 * BP);
    chk("b2b_data", 32'(o_data), 32'h80);

    // Glitch shorter than half a bit
    tick(BP);
    ser = 1'b0;
    tick(20);
    chk("glitch_busy", 32'(o_rx_busy), 32'h1);
    ser = 1'b1;
    tick(HALF + 10);
    chk("glitch_idle", 32'(o_rx_busy), 32'h0);
    chk("glitch_nopulse", 32'(exp_q.size()), 32'h0);
    push(1'b0, 8'h55);
    send_frame(8'h55, 1'b1);
    wait_drain(2 * BP);

    // Framing error followed by a held-low break
    tick(BP);
    push(1'b1, 8'h55);
    send_frame(8'h81, 1'b0);
    tick(3 * BP);
    chk("ferr_seen", 32'(exp_q.size()), 32'h0);
    chk("ferr_waithigh", 32'(o_rx_busy), 32'h1);
    chk("ferr_data_kept", 32'(o_data), 32'h55);
    ser = 1'b1;
    tick(BP);
    chk("ferr_released", 32'(o_rx_busy), 32'h0);
    push(1'b0, 8'h42);
    send_frame(8'h42, 1'b1);
    wait_drain(2 * BP);

    // Reset during data bit 4 of 0xF0
    tick(BP);
    ser = 1'b0;
    tick(BP);
    for (int i = 0; i < 4; i++) begin
      ser = 1'b0;
      tick(BP);
    end
    ser = 1'b1;
    tick(40);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midrst_data", 32'(o_data), 32'h0);
    chk("midrst_busy", 32'(o_rx_busy), 32'h0);
    chk("midrst_done", 32'(o_rx_done), 32'h0);
    chk("midrst_err", 32'(o_frame_err), 32'h0);
    tick(BP - 41 + 4 * BP);
    chk("midrst_nopulse", 32'(exp_q.size()), 32'h0);
    push(1'b0, 8'h0F);
    send_frame(8'h0F, 1'b1);
    wait_drain(2 * BP);

    // Loopback sweep across the byte range
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'(i * 4 + (i & 3));
      push(1'b0, b);
      send_frame(b, 1'b1);
    end
    wait_drain(2 * BP);
    chk("sweep_last", 32'(o_data), 32'hFF);
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
